// File: rtl/arp_pkg.sv
// Shared constants and FSM state type for the ARP reply generator.
package arp_pkg;

    localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  ARP_HLEN_ETH     = 8'd6;
    localparam logic [7:0]  ARP_PLEN_IPV4    = 8'd4;
    localparam logic [15:0] ARP_OPER_REQUEST = 16'd1;
    localparam logic [15:0] ARP_OPER_REPLY   = 16'd2;

    localparam int unsigned STATE_WIDTH = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        StIdle    = 2'd0,
        StCheck   = 2'd1,
        StCacheWr = 2'd2,
        StReply   = 2'd3
    } arp_state_e;

endpackage

// File: rtl/arp_frame_classify.sv
// Combinational classification of a registered ARP frame against the local config.
module arp_frame_classify
    import arp_pkg::*;
(
    input  logic [15:0] htype,
    input  logic [15:0] ptype,
    input  logic [7:0]  hlen,
    input  logic [7:0]  plen,
    input  logic [15:0] oper,
    input  logic [31:0] spa,
    input  logic [31:0] tpa,
    input  logic        cfg_enable,
    input  logic [31:0] cfg_local_ip,
    output logic        hdr_ok,
    output logic        for_us,
    output logic        learn,
    output logic        reply
);

    always_comb begin
        hdr_ok = (htype == ARP_HTYPE_ETH) && (ptype == ARP_PTYPE_IPV4) &&
                 (hlen == ARP_HLEN_ETH) && (plen == ARP_PLEN_IPV4);
        for_us = hdr_ok && (tpa == cfg_local_ip) && cfg_enable;
        // spa==0 is an address probe: answer it, but there is nothing to learn.
        learn  = for_us && (spa != 32'd0);
        reply  = for_us && (oper == ARP_OPER_REQUEST);
    end

endmodule

// File: rtl/arp_reply_gen.sv
// ARP frame consumer: learns sender bindings into the cache and answers requests for our IP.
module arp_reply_gen
    import arp_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 s_frame_valid,
    output logic                 s_frame_ready,
    input  logic [47:0]          s_eth_dest_mac,
    input  logic [47:0]          s_eth_src_mac,
    input  logic [15:0]          s_eth_type,
    input  logic [15:0]          s_arp_htype,
    input  logic [15:0]          s_arp_ptype,
    input  logic [7:0]           s_arp_hlen,
    input  logic [7:0]           s_arp_plen,
    input  logic [15:0]          s_arp_oper,
    input  logic [47:0]          s_arp_sha,
    input  logic [47:0]          s_arp_tha,
    input  logic [31:0]          s_arp_spa,
    input  logic [31:0]          s_arp_tpa,

    output logic                 m_frame_valid,
    input  logic                 m_frame_ready,
    output logic [47:0]          m_eth_dest_mac,
    output logic [47:0]          m_eth_src_mac,
    output logic [15:0]          m_eth_type,
    output logic [15:0]          m_arp_htype,
    output logic [15:0]          m_arp_ptype,
    output logic [7:0]           m_arp_hlen,
    output logic [7:0]           m_arp_plen,
    output logic [15:0]          m_arp_oper,
    output logic [47:0]          m_arp_sha,
    output logic [47:0]          m_arp_tha,
    output logic [31:0]          m_arp_spa,
    output logic [31:0]          m_arp_tpa,

    output logic                 m_cache_wr_valid,
    input  logic                 m_cache_wr_ready,
    output logic [31:0]          m_cache_wr_ip,
    output logic [47:0]          m_cache_wr_mac,

    input  logic                 cfg_enable,
    input  logic [47:0]          cfg_local_mac,
    input  logic [31:0]          cfg_local_ip,

    output logic                 busy,
    output logic [CNT_WIDTH-1:0] stat_reply_count,
    output logic [CNT_WIDTH-1:0] stat_learn_count,
    output logic [CNT_WIDTH-1:0] stat_drop_count
);

    arp_state_e state_q, state_d;
    logic       ready_q, ready_d;

    logic [47:0] eth_src_q;
    logic [15:0] htype_q, ptype_q, oper_q;
    logic [7:0]  hlen_q, plen_q;
    logic [47:0] sha_q;
    logic [31:0] spa_q, tpa_q;

    logic [47:0] cfg_mac_q;
    logic [31:0] cfg_ip_q;
    logic        reply_q;

    logic [CNT_WIDTH-1:0] reply_cnt_q, learn_cnt_q, drop_cnt_q;

    logic cls_hdr_ok, cls_for_us, cls_learn, cls_reply;
    logic accept, drop_evt, learn_evt, reply_evt;

    arp_frame_classify u_classify (
        .htype        (htype_q),
        .ptype        (ptype_q),
        .hlen         (hlen_q),
        .plen         (plen_q),
        .oper         (oper_q),
        .spa          (spa_q),
        .tpa          (tpa_q),
        .cfg_enable   (cfg_enable),
        .cfg_local_ip (cfg_local_ip),
        .hdr_ok       (cls_hdr_ok),
        .for_us       (cls_for_us),
        .learn        (cls_learn),
        .reply        (cls_reply)
    );

    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        drop_evt         = 1'b0;
        learn_evt        = 1'b0;
        reply_evt        = 1'b0;
        m_cache_wr_valid = 1'b0;
        m_frame_valid    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s_frame_valid && ready_q) begin
                    accept  = 1'b1;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (cls_learn) begin
                    state_d = StCacheWr;
                end else if (cls_reply) begin
                    state_d = StReply;
                end else begin
                    drop_evt = 1'b1;
                    state_d  = StIdle;
                end
            end
            StCacheWr: begin
                m_cache_wr_valid = 1'b1;
                if (m_cache_wr_ready) begin
                    learn_evt = 1'b1;
                    state_d   = reply_q ? StReply : StIdle;
                end
            end
            StReply: begin
                m_frame_valid = 1'b1;
                if (m_frame_ready) begin
                    reply_evt = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Ready only after a full idle cycle, giving the 3-cycle minimum frame spacing.
        ready_d = (state_q == StIdle) && (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eth_src_q <= '0;
            htype_q   <= '0;
            ptype_q   <= '0;
            hlen_q    <= '0;
            plen_q    <= '0;
            oper_q    <= '0;
            sha_q     <= '0;
            spa_q     <= '0;
            tpa_q     <= '0;
        end else if (accept) begin
            eth_src_q <= s_eth_src_mac;
            htype_q   <= s_arp_htype;
            ptype_q   <= s_arp_ptype;
            hlen_q    <= s_arp_hlen;
            plen_q    <= s_arp_plen;
            oper_q    <= s_arp_oper;
            sha_q     <= s_arp_sha;
            spa_q     <= s_arp_spa;
            tpa_q     <= s_arp_tpa;
        end
    end

    // Config is frozen at CHECK so later changes cannot alter a frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mac_q <= '0;
            cfg_ip_q  <= '0;
            reply_q   <= 1'b0;
        end else if (state_q == StCheck) begin
            cfg_mac_q <= cfg_local_mac;
            cfg_ip_q  <= cfg_local_ip;
            reply_q   <= cls_reply;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reply_cnt_q <= '0;
            learn_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (reply_evt) reply_cnt_q <= reply_cnt_q + CNT_WIDTH'(1);
            if (learn_evt) learn_cnt_q <= learn_cnt_q + CNT_WIDTH'(1);
            if (drop_evt)  drop_cnt_q  <= drop_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign s_frame_ready    = ready_q;
    assign busy             = (state_q != StIdle);

    assign m_cache_wr_ip    = spa_q;
    assign m_cache_wr_mac   = sha_q;

    assign m_eth_dest_mac   = eth_src_q;
    assign m_eth_src_mac    = cfg_mac_q;
    assign m_eth_type       = ETHERTYPE_ARP;
    assign m_arp_htype      = ARP_HTYPE_ETH;
    assign m_arp_ptype      = ARP_PTYPE_IPV4;
    assign m_arp_hlen       = ARP_HLEN_ETH;
    assign m_arp_plen       = ARP_PLEN_IPV4;
    assign m_arp_oper       = ARP_OPER_REPLY;
    assign m_arp_sha        = cfg_mac_q;
    assign m_arp_spa        = cfg_ip_q;
    assign m_arp_tha        = sha_q;
    assign m_arp_tpa        = spa_q;

    assign stat_reply_count = reply_cnt_q;
    assign stat_learn_count = learn_cnt_q;
    assign stat_drop_count  = drop_cnt_q;

    logic unused_fields;
    assign unused_fields = ^{s_eth_dest_mac, s_eth_type, s_arp_tha, cls_hdr_ok, cls_for_us};

endmodule
